display_mux_scheduler: RTL and testbench

//  Time-multiplexes the single shared seven-segment decoder between the two keypad digits.
//  sw1 (older key) goes to digit 0 and sw2 (newest key) to digit 1.

---
 rtl/display_mux_scheduler.sv | 144 ++++++++++++++
 tb/tb_display_mux_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - two-digit seven-segment time multiplexer with dead time and frame-aligned key updates
// Optional feature: BLANK_ZERO_EN (blank digit 0 while its shadow value is zero).
module display_mux_scheduler #(
    parameter int REFRESH_CYCLES = 24000,
    parameter int DEAD_CYCLES    = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw1,
    input  logic [3:0] sw2,
    input  logic       upd,
    output logic [3:0] hex,
    output logic [1:0] an,
    output logic       frame_done
);

    localparam int MAX_LEN  = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
    localparam int MAX_LEN2 = (MAX_LEN > 2) ? MAX_LEN : 2;
    localparam int CW       = $clog2(MAX_LEN2);

    typedef enum logic [1:0] {SHOW0, DEAD0, SHOW1, DEAD1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          run;
    logic [3:0]    shadow0, shadow1, shadow0_n, shadow1_n;
    logic [3:0]    pend0, pend1, pend0_n, pend1_n;
    logic          pend_v, pend_v_n;
    logic          boundary;
    logic [3:0]    hex_n;
    logic [1:0]    an_n;
    logic          frame_done_n;

    function automatic logic is_last(input state_t st, input logic [CW-1:0] c);
        if (st == SHOW0 || st == SHOW1)
            return int'(c) == REFRESH_CYCLES - 1;
        else
            return int'(c) == DEAD_CYCLES - 1;
    endfunction

    // The frame ends on the last DEAD1 cycle, or on the last SHOW1 cycle when dead time is disabled.
    function automatic logic is_boundary(input state_t st, input logic [CW-1:0] c);
        return is_last(st, c) && ((DEAD_CYCLES == 0) ? (st == SHOW1) : (st == DEAD1));
    endfunction

    function automatic state_t next_state(input state_t st);
        case (st)
            SHOW0:   return (DEAD_CYCLES == 0) ? SHOW1 : DEAD0;
            DEAD0:   return SHOW1;
            SHOW1:   return (DEAD_CYCLES == 0) ? SHOW0 : DEAD1;
            default: return SHOW0;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shadow0_n = shadow0;
        shadow1_n = shadow1;
        pend0_n   = pend0;
        pend1_n   = pend1;
        pend_v_n  = pend_v;
        boundary  = run && is_boundary(state, cnt);

        // The first cycle out of reset only arms the sequencer so SHOW0 cnt=0 is the first lit cycle.
        if (run) begin
            if (is_last(state, cnt)) begin
                state_n = next_state(state);
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end

        if (boundary) begin
            pend_v_n = 1'b0;
            if (upd) begin
                shadow0_n = sw1;
                shadow1_n = sw2;
            end else if (pend_v) begin
                shadow0_n = pend0;
                shadow1_n = pend1;
            end
        end else if (upd) begin
            pend0_n  = sw1;
            pend1_n  = sw2;
            pend_v_n = 1'b1;
        end

        // Outputs are decoded from the next state so they line up with the state they belong to.
        case (state_n)
            SHOW0: begin
                an_n  = 2'b10;
                hex_n = shadow0_n;
`ifdef BLANK_ZERO_EN
                if (shadow0_n == 4'h0)
                    an_n = 2'b11;
`endif
            end
            DEAD0: begin
                an_n  = 2'b11;
                hex_n = shadow1_n;
            end
            SHOW1: begin
                an_n  = 2'b01;
                hex_n = shadow1_n;
            end
            default: begin
                an_n  = 2'b11;
                hex_n = pend_v_n ? pend0_n : shadow0_n;
            end
        endcase
        frame_done_n = is_boundary(state_n, cnt_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SHOW0;
            cnt        <= '0;
            run        <= 1'b0;
            shadow0    <= 4'h0;
            shadow1    <= 4'h0;
            pend0      <= 4'h0;
            pend1      <= 4'h0;
            pend_v     <= 1'b0;
            an         <= 2'b11;
            hex        <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            run        <= 1'b1;
            shadow0    <= shadow0_n;
            shadow1    <= shadow1_n;
            pend0      <= pend0_n;
            pend1      <= pend1_n;
            pend_v     <= pend_v_n;
            an         <= an_n;
            hex        <= hex_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - scoreboard bench for display_mux_scheduler
module tb_display_mux_scheduler;

    localparam int R     = 8;
    localparam int D     = 2;
    localparam int FRAME = 2 * (R + D);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw1 = 4'h0;
    logic [3:0] sw2 = 4'h0;
    logic       upd = 1'b0;
    logic [3:0] hex;
    logic [1:0] an;
    logic       frame_done;

    display_mux_scheduler #(.REFRESH_CYCLES(R), .DEAD_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw1        (sw1),
        .sw2        (sw2),
        .upd        (upd),
        .hex        (hex),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [3:0] hex;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    bit   active = 0;
    bit   done   = 0;

    // Reference model: digit pair per frame, plus the latest pair requested during this frame.
    int         k;
    logic [3:0] cur0, cur1, nx0, nx1;
    bit         nxt_v;

    task automatic model_restart();
        k = 0; cur0 = 4'h0; cur1 = 4'h0; nx0 = 4'h0; nx1 = 4'h0; nxt_v = 0;
    endtask

    task automatic drive_cycle(input bit u, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   pos;
        @(negedge clk);
        active = 1;
        pos = k % FRAME;
        if (pos == 0 && k > 0 && nxt_v) begin
            cur0 = nx0; cur1 = nx1; nxt_v = 0;
        end
        e.cyc = k;
        e.fd  = (pos == FRAME - 1);
        if (pos < R) begin
            e.an  = 2'b10;
`ifdef BLANK_ZERO_EN
            if (cur0 == 4'h0) e.an = 2'b11;
`endif
            e.hex = cur0;
        end else if (pos < R + D) begin
            e.an = 2'b11; e.hex = cur1;
        end else if (pos < 2 * R + D) begin
            e.an = 2'b01; e.hex = cur1;
        end else begin
            e.an = 2'b11; e.hex = nxt_v ? nx0 : cur0;
        end
        sb.push_back(e);
        upd = u; sw1 = a; sw2 = b;
        if (u) begin
            nx0 = a; nx1 = b; nxt_v = 1;
        end
        k++;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (an !== 2'b11 || hex !== 4'h0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL %s: an=%b hex=%h fd=%b, required an=11 hex=0 fd=0", tag, an, hex, frame_done);
        end
    endtask

    task automatic random_cycle(input bit force_upd, input logic [3:0] fa, input logic [3:0] fb);
        logic [3:0] a, b;
        bit u;
        if (force_upd) begin
            drive_cycle(1'b1, fa, fb);
        end else begin
            u = ($urandom_range(7) == 0);
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            if ((k % FRAME) == FRAME - 1 && ((k / FRAME) % 3) == 1) u = 1;
            drive_cycle(u, a, b);
        end
    endtask

    // Monitor: one output set per cycle while the sequencer is running.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #1;
            if (active && !done) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_underflow: got an=%b hex=%h, required a queued expectation", an, hex);
                end else begin
                    e = sb.pop_front();
                    if (an !== e.an || hex !== e.hex || frame_done !== e.fd) begin
                        fails++;
                        $display("FAIL out_cycle%0d: got an=%b hex=%h fd=%b, required an=%b hex=%h fd=%b",
                                 e.cyc, an, hex, frame_done, e.an, e.hex, e.fd);
                    end
                end
                checks++;
                if (an === 2'b00) begin
                    fails++;
                    $display("FAIL an_both_lit: got an=%b, required not 00", an);
                end
            end
        end
    end

    initial begin
        model_restart();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("reset_state");
        end
        reset = 1'b0;

        for (int i = 0; i <= 392; i++) begin
            case (k)
                3:       random_cycle(1, 4'h0, 4'h6);
                25:      random_cycle(1, 4'h6, 4'h8);
                30:      random_cycle(1, 4'h8, 4'h3);
                59:      random_cycle(1, 4'h5, 4'hA);
                385:     random_cycle(1, 4'h7, 4'h9);
                default: begin
                    if (k < 60) drive_cycle(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
                    else        random_cycle(0, 4'h0, 4'h0);
                end
            endcase
        end

        // Mid-SHOW1 reset with a pending pair; the pair must be discarded.
        reset = 1'b1;
        upd   = 1'b0;
        @(negedge clk);
        active = 0;
        #1 check_reset_outputs("midframe_reset");
        @(negedge clk);
        #1 check_reset_outputs("midframe_reset_hold");
        reset = 1'b0;
        sb.delete();
        model_restart();

        for (int i = 0; i < 160; i++) begin
            if (i < 40) drive_cycle(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
            else        random_cycle(0, 4'h0, 4'h0);
        end

        @(negedge clk);
        upd = 1'b0;
        active = 0;
        #2;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
